// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter between a single-cycle ALU
// result path and a queued multi-cycle (MDU) result path.
//  - ALU results win the write port; MDU results wait in a small FIFO.
//  - A starve counter forces a one-cycle ALU stall so the FIFO head drains.
//  - Optional pending-register mask, built only with WB_PENDING_MASK_EN.
module wb_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_addr_i,
  input  logic [31:0] alu_data_i,
  input  logic        mdu_valid_i,
  input  logic [4:0]  mdu_addr_i,
  input  logic [31:0] mdu_data_i,
  output logic        mdu_ready_o,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] RDdata_o,
  output logic [31:0] pending_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C     = (AW+1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

  logic [4:0]    fifo_addr_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          we_q, we_d;
  logic [4:0]    waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic fifo_empty, alu_take, head_sel, enq;

  // Address-0 results are accepted but dropped; a stalled ALU is ignored.
  assign fifo_empty  = (count_q == '0);
  assign mdu_ready_o = !rst_i && (count_q < DEPTH_C);
  assign alu_take    = !stall_q && alu_valid_i && (alu_addr_i != 5'd0);
  assign head_sel    = !fifo_empty && !alu_take;
  assign enq         = mdu_valid_i && mdu_ready_o && (mdu_addr_i != 5'd0);

  assign stall_o    = stall_q;
  assign RegWrite_o = we_q;
  assign RDaddr_o   = waddr_q;
  assign RDdata_o   = wdata_q;

  // Pick this cycle's write source; address/data hold when nothing writes.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (alu_take) begin
      we_d    = 1'b1;
      waddr_d = alu_addr_i;
      wdata_d = alu_data_i;
    end else if (head_sel) begin
      we_d    = 1'b1;
      waddr_d = fifo_addr_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
    end
  end

  // Occupancy: push and pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (enq && !head_sel)      count_d = count_q + (AW+1)'(1);
    else if (!enq && head_sel) count_d = count_q - (AW+1)'(1);
  end

  // Count cycles the head is blocked; on the limit fire a one-cycle stall.
  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (fifo_empty || head_sel) begin
      starve_d = '0;
    end else if (starve_q == STARVE_LAST) begin
      starve_d = '0;
      stall_d  = 1'b1;
    end else begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Control and write-port registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      if (head_sel) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (enq)      wr_ptr_q <= wr_ptr_q + AW'(1);
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  // FIFO payload storage; validity is tracked by the pointers/count.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_addr_q[wr_ptr_q] <= mdu_addr_i;
      fifo_data_q[wr_ptr_q] <= mdu_data_i;
    end
  end

`ifdef WB_PENDING_MASK_EN
  logic [FIFO_DEPTH-1:0] slot_vld_q;

  // Per-slot occupancy so stale payload never shows up in the mask.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_vld_q <= '0;
    end else begin
      if (enq)      slot_vld_q[wr_ptr_q] <= 1'b1;
      if (head_sel) slot_vld_q[rd_ptr_q] <= 1'b0;
    end
  end

  // OR together the target registers of all occupied slots.
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_vld_q[i]) pending_o[fifo_addr_q[i]] = 1'b1;
    end
    pending_o[0] = 1'b0;
  end
`else
  assign pending_o = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
`ifdef WB_PENDING_MASK_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_v, mdu_v;
  logic [4:0]  alu_a, mdu_a;
  logic [31:0] alu_d, mdu_d;
  logic        mdu_ready, stall, we;
  logic [4:0]  rdaddr;
  logic [31:0] rddata, pending;

  always #5 clk = ~clk;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(alu_v), .alu_addr_i(alu_a), .alu_data_i(alu_d),
    .mdu_valid_i(mdu_v), .mdu_addr_i(mdu_a), .mdu_data_i(mdu_d),
    .mdu_ready_o(mdu_ready), .stall_o(stall),
    .RegWrite_o(we), .RDaddr_o(rdaddr), .RDdata_o(rddata),
    .pending_o(pending)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h @%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  int          m_blocked = 0;
  bit          m_stall = 0;
  bit          m_we = 0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          cmp_en = 0;
  int          n_pre;
  bit          take_alu, take_head, push, nxt_stall;

  // The write port takes at most one result per clock; ALU first unless the
  // queue has been passed over LIMIT times in a row.
  always @(posedge clk) begin
    if (rst) begin
      q.delete(); m_blocked = 0; m_stall = 0; m_we = 0; m_addr = '0; m_data = '0;
    end else begin
      n_pre     = q.size();
      take_alu  = !m_stall && alu_v && (alu_a != 0);
      take_head = (n_pre > 0) && !take_alu;
      push      = mdu_v && (n_pre < DEPTH) && (mdu_a != 0);
      m_we = take_alu || take_head;
      if (take_alu) begin
        m_addr = alu_a; m_data = alu_d;
      end else if (take_head) begin
        m_addr = q[0].a; m_data = q[0].d; void'(q.pop_front());
      end
      nxt_stall = 0;
      if (n_pre == 0 || take_head) m_blocked = 0;
      else begin
        m_blocked++;
        if (m_blocked == LIMIT) begin m_blocked = 0; nxt_stall = 1; end
      end
      m_stall = nxt_stall;
      if (push) q.push_back('{a: mdu_a, d: mdu_d});
    end
  end

  function automatic logic [31:0] exp_pending();
    logic [31:0] p = '0;
    foreach (q[i]) p[q[i].a] = 1'b1;
    p[0] = 1'b0;
    return PEND_EN ? p : 32'h0;
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("RegWrite", 32'(we), 32'(m_we));
      chk("RDaddr", 32'(rdaddr), 32'(m_addr));
      chk("RDdata", rddata, m_data);
      chk("stall", 32'(stall), 32'(m_stall));
      chk("mdu_ready", 32'(mdu_ready), 32'(!rst && q.size() < DEPTH));
      chk("pending", pending, exp_pending());
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    alu_v = 0; alu_a = '0; alu_d = '0;
    mdu_v = 0; mdu_a = '0; mdu_d = '0;
  endtask
  task automatic next();
    @(posedge clk); #2;
  endtask
  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    alu_v = 1; alu_a = a; alu_d = d;
  endtask
  task automatic mdu(input logic [4:0] a, input logic [31:0] d);
    mdu_v = 1; mdu_a = a; mdu_d = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int alu_pct, mdu_pct;
    idle(); rst = 1;
    next(); cmp_en = 1;
    next();
    @(negedge clk);
    chk("rst_RegWrite", 32'(we), 32'd0);
    chk("rst_RDaddr", 32'(rdaddr), 32'd0);
    chk("rst_RDdata", rddata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd0);
    chk("rst_pending", pending, 32'd0);
    next(); rst = 0;
    next();
    @(negedge clk);
    chk("post_rst_ready", 32'(mdu_ready), 32'd1);

    // ALU single write, latency 1
    next(); alu(5'd5, 32'h1234);
    next(); idle();
    @(negedge clk);
    chk("alu_we", 32'(we), 32'd1);
    chk("alu_addr", 32'(rdaddr), 32'd5);
    chk("alu_data", rddata, 32'h1234);

    // MDU write, latency 2
    next(); mdu(5'd7, 32'hDEAD);
    next(); idle();
    @(negedge clk);
    chk("mdu_lat1_we", 32'(we), 32'd0);
    next();
    @(negedge clk);
    chk("mdu_lat2_we", 32'(we), 32'd1);
    chk("mdu_lat2_addr", 32'(rdaddr), 32'd7);
    chk("mdu_lat2_data", rddata, 32'hDEAD);

    // Same-register collision: ALU first, MDU value final
    next(); alu(5'd3, 32'd1); mdu(5'd3, 32'd2);
    next(); idle();
    @(negedge clk);
    chk("coll_first", {rdaddr, rddata[26:0]}, {5'd3, 27'd1});
    next();
    @(negedge clk);
    chk("coll_second", {rdaddr, rddata[26:0]}, {5'd3, 27'd2});

    // Fill FIFO under continuous ALU traffic, then starvation stall
    next();
    for (int k = 0; k < 4; k++) begin
      alu(5'd4, 32'(k)); mdu(5'(8 + k), 32'(100 + k));
      next();
    end
    mdu_v = 0;
    @(negedge clk);
    chk("full_ready", 32'(mdu_ready), 32'd0);
    for (int c = 4; c <= 10; c++) begin
      if (c > 4) @(negedge clk);
      chk($sformatf("starve_stall_c%0d", c), 32'(stall), 32'(c == 9));
      if (c == 10) begin
        chk("starve_drain_addr", 32'(rdaddr), 32'd8);
        chk("starve_drain_data", rddata, 32'd100);
        chk("starve_ready", 32'(mdu_ready), 32'd1);
      end
      next();
    end
    idle();
    repeat (4) next();

    // Address 0 on both paths: nothing written, nothing queued, port holds
    alu(5'd0, 32'h55); mdu(5'd0, 32'h66);
    next(); idle();
    @(negedge clk);
    chk("zero_we", 32'(we), 32'd0);
    chk("zero_hold_addr", 32'(rdaddr), 32'd11);
    chk("zero_ready", 32'(mdu_ready), 32'd1);
    next();
    @(negedge clk);
    chk("zero_we2", 32'(we), 32'd0);

    // Reset with three queued entries
    next();
    for (int k = 0; k < 3; k++) begin
      alu(5'd4, 32'(k)); mdu(5'(12 + k), 32'(200 + k));
      next();
    end
    mdu_v = 0;
    @(negedge clk);
    chk("queued_pending", pending, PEND_EN ? 32'h0000_7000 : 32'h0);
    next(); idle(); rst = 1;
    next();
    @(negedge clk);
    chk("midrst_we", 32'(we), 32'd0);
    chk("midrst_pending", pending, 32'd0);
    chk("midrst_ready", 32'(mdu_ready), 32'd0);
    next(); rst = 0;
    @(negedge clk);
    chk("release_ready", 32'(mdu_ready), 32'd1);
    chk("release_we", 32'(we), 32'd0);
    next();

    // Randomized traffic in epochs of varying pressure
    alu_pct = 50; mdu_pct = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) begin
        alu_pct = (cyc % 600 == 0) ? 95 : ((cyc % 400 == 0) ? 20 : 60);
        mdu_pct = $urandom_range(1) ? 70 : 30;
      end
      rst   = ($urandom_range(249) == 0);
      alu_v = ($urandom_range(99) < alu_pct);
      alu_a = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      alu_d = $urandom;
      mdu_v = ($urandom_range(99) < mdu_pct);
      mdu_a = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      mdu_d = $urandom;
      next();
    end
    rst = 0; idle();
    repeat (12) next();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
